// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared constants, divisor defaults and config FSM state type for tick_sched
package tick_sched_pkg;

    localparam int NUM_CH   = 3;
    localparam int CNT_W    = 27;
    localparam int CH_W     = 3;
    localparam int DIV0_DEF = 4;
    localparam int DIV1_DEF = 200000;
    localparam int DIV2_DEF = 100000000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WRAP,
        DONE,
        ERR
    } cfg_state_t;

endpackage

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one tick channel: wrap counter, divisor register, registered tick
// TICK_SQUARE_OUT_EN adds a toggling square-wave output per channel.
module tick_chan #(
    parameter int CNT_W   = tick_sched_pkg::CNT_W,
    parameter int DIV_RST = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] div_i,
`ifdef TICK_SQUARE_OUT_EN
    output logic             sq_o,
`endif
    output logic             tick_o,
    output logic             wrap_o,
    output logic             dis_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q;

    assign dis_o  = (div_q == '0);
    assign wrap_o = run_i && !dis_o && (cnt_q == div_q - CNT_W'(1));
    assign tick_o = tick_q;

    // An applied divisor always starts its new period from zero.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run_i || dis_o || wrap_o || apply_i) begin
            cnt_d = '0;
        end
        div_d = apply_i ? div_i : div_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DIV_RST);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= wrap_o;
        end
    end

`ifdef TICK_SQUARE_OUT_EN
    logic sq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_q <= 1'b0;
        end else if (!run_i || dis_o) begin
            sq_q <= 1'b0;
        end else if (wrap_o) begin
            sq_q <= ~sq_q;
        end
    end

    assign sq_o = sq_q;
`endif

endmodule

// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - multi-channel clock-enable tick scheduler with run-time divisor config port
// Optional TICK_SQUARE_OUT_EN adds clk_sq square-wave outputs.
module tick_sched #(
    parameter int NUM_CH   = tick_sched_pkg::NUM_CH,
    parameter int CNT_W    = tick_sched_pkg::CNT_W,
    parameter int DIV0_DEF = tick_sched_pkg::DIV0_DEF,
    parameter int DIV1_DEF = tick_sched_pkg::DIV1_DEF,
    parameter int DIV2_DEF = tick_sched_pkg::DIV2_DEF
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic                            run,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [tick_sched_pkg::CH_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                cfg_div,
    output logic                            cfg_done,
    output logic                            cfg_err,
`ifdef TICK_SQUARE_OUT_EN
    output logic [NUM_CH-1:0]               clk_sq,
`endif
    output logic [NUM_CH-1:0]               tick
);

    import tick_sched_pkg::*;

    localparam int CH_N = 1 << CH_W;

    cfg_state_t       state_q, state_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             err_q;
    logic             apply_now;

    logic [NUM_CH-1:0] wrap_w, dis_w;
    logic [CH_N-1:0]   wrap_ext, dis_ext;

    // Widened to the full index range so pend_ch can select without width juggling.
    assign wrap_ext = CH_N'(wrap_w);
    assign dis_ext  = CH_N'(dis_w);

    always_comb begin
        state_d    = state_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        apply_now  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (int'(cfg_ch) >= NUM_CH) begin
                        state_d = ERR;
                    end else begin
                        state_d    = WAIT_WRAP;
                        pend_ch_d  = cfg_ch;
                        pend_div_d = cfg_div;
                    end
                end
            end
            WAIT_WRAP: begin
                if (wrap_ext[pend_ch_q] || dis_ext[pend_ch_q] || !run) begin
                    apply_now = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            err_q      <= (state_q == ERR);
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign cfg_done  = (state_q == DONE);
    assign cfg_err   = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int DEF = (i == 0) ? DIV0_DEF :
                             (i == 1) ? DIV1_DEF :
                             (i == 2) ? DIV2_DEF : 0;

        tick_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DEF)
        ) u_chan (
            .clk_i   (sys_clk),
            .rst_ni  (sys_rst_n),
            .run_i   (run),
            .apply_i (apply_now && (pend_ch_q == CH_W'(i))),
            .div_i   (pend_div_q),
`ifdef TICK_SQUARE_OUT_EN
            .sq_o    (clk_sq[i]),
`endif
            .tick_o  (tick[i]),
            .wrap_o  (wrap_w[i]),
            .dis_o   (dis_w[i])
        );
    end

endmodule

// File: tb/tb_tick_sched.sv
// tb/tb_tick_sched.sv - self-checking bench for tick_sched against a timestamp-based reference model
module tb_tick_sched;

    localparam int NCH = 3;
    localparam int CW  = 27;
    localparam int D0  = 4;
    localparam int D1  = 20;
    localparam int D2  = 50;

    typedef struct {
        int             off;
        logic [NCH-1:0] tk;
    } vec_t;

    logic            sys_clk   = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            run       = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [2:0]      cfg_ch    = '0;
    logic [CW-1:0]   cfg_div   = '0;
    logic            cfg_ready;
    logic            cfg_done;
    logic            cfg_err;
    logic [NCH-1:0]  tick;
`ifdef TICK_SQUARE_OUT_EN
    logic [NCH-1:0]  clk_sq;
`endif

    tick_sched #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DIV0_DEF (D0),
        .DIV1_DEF (D1),
        .DIV2_DEF (D2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
`ifdef TICK_SQUARE_OUT_EN
        .clk_sq    (clk_sq),
`endif
        .tick      (tick)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a channel ticks when a whole number of its periods has elapsed
    // since the edge where its count last restarted.
    int             m_div   [NCH];
    int             m_start [NCH];
    bit             m_pend;
    int             m_pch;
    int             m_pdiv;
    int             m_done_at;
    int             m_err_at;
    int             m_errst_at;
    bit             m_ready;
    logic [NCH-1:0] m_tick;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_div[0] = D0;
        m_div[1] = D1;
        m_div[2] = D2;
        for (int i = 0; i < NCH; i++) m_start[i] = cyc;
        m_pend     = 1'b0;
        m_done_at  = -1;
        m_err_at   = -1;
        m_errst_at = -1;
        m_ready    = 1'b1;
        m_tick     = '0;
    endfunction

    function automatic void m_edge();
        logic [NCH-1:0] t;
        t = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!run || m_div[i] == 0) begin
                m_start[i] = cyc;
            end else if (((cyc - m_start[i]) % m_div[i]) == 0) begin
                t[i]       = 1'b1;
                m_start[i] = cyc;
            end
        end
        if (m_pend) begin
            if (t[m_pch] || m_div[m_pch] == 0 || !run) begin
                m_div[m_pch]   = m_pdiv;
                m_start[m_pch] = cyc;
                m_pend         = 1'b0;
                m_done_at      = cyc;
            end
        end else if (m_ready && cfg_valid) begin
            if (int'(cfg_ch) >= NCH) begin
                m_errst_at = cyc;
                m_err_at   = cyc + 1;
            end else begin
                m_pend = 1'b1;
                m_pch  = int'(cfg_ch);
                m_pdiv = int'(cfg_div);
            end
        end
        m_tick  = t;
        m_ready = !m_pend && (m_done_at != cyc) && (m_errst_at != cyc);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        cyc++;
        if (!sys_rst_n) m_reset();
        else            m_edge();
        #1;
        chk("model_outputs", int'({tick, cfg_ready, cfg_done, cfg_err}),
            int'({m_tick, m_ready, (m_done_at == cyc), (m_err_at == cyc)}));
    endtask

    task automatic send(input int ch, input int dv);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = CW'(dv);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        vec_t tbl [11];
        int   base, t0, cnt;
        bit   seen;

        tbl[0]  = '{1,  3'b000};
        tbl[1]  = '{3,  3'b000};
        tbl[2]  = '{4,  3'b001};
        tbl[3]  = '{5,  3'b000};
        tbl[4]  = '{8,  3'b001};
        tbl[5]  = '{19, 3'b000};
        tbl[6]  = '{20, 3'b011};
        tbl[7]  = '{40, 3'b011};
        tbl[8]  = '{48, 3'b001};
        tbl[9]  = '{50, 3'b100};
        tbl[10] = '{60, 3'b011};

        m_reset();
        #1;
        chk("reset_outputs", int'({tick, cfg_ready, cfg_done, cfg_err}), 6'b000100);
        repeat (3) step();
        sys_rst_n = 1'b1;
        step();
        run  = 1'b1;
        base = cyc;
        for (int k = 0; k < 60; k++) begin
            step();
            for (int v = 0; v < 11; v++)
                if (tbl[v].off == cyc - base) chk("default_tick", int'(tick), int'(tbl[v].tk));
        end

        // ch0 -> 10, requested while cnt0 == 1
        for (int g = 0; g < 10 && ((cyc - m_start[0]) % m_div[0]) != 1; g++) step();
        send(0, 10);
        t0 = cyc;
        chk("A_ready_low", int'(cfg_ready), 0);
        step();
        chk("A_done_early", int'(cfg_done), 0);
        step();
        chk("A_done", int'(cfg_done), 1);
        cnt = 0;
        for (int k = 3; k <= 22; k++) begin
            step();
            cnt += int'(tick[0]);
            if (k == 11) chk("A_no_short_period", int'(tick[0]), 0);
            if (k == 12) chk("A_first_new_tick", int'(tick[0]), 1);
            if (k == 22) chk("A_second_new_tick", int'(tick[0]), 1);
        end
        chk("A_tick_count", cnt, 2);

        // out-of-range channel
        send(5, 3);
        chk("B_ready_low", int'(cfg_ready), 0);
        chk("B_err_early", int'(cfg_err), 0);
        step();
        chk("B_err", int'(cfg_err), 1);
        chk("B_no_done", int'(cfg_done), 0);
        step();
        chk("B_err_once", int'(cfg_err), 0);

        // disable ch1, then re-enable at 7
        send(1, 0);
        seen = 1'b0;
        for (int g = 0; g < 30 && !seen; g++) begin
            step();
            seen = cfg_done;
        end
        chk("C_disable_done_seen", int'(seen), 1);
        cnt = 0;
        for (int k = 0; k < 45; k++) begin
            step();
            cnt += int'(tick[1]);
        end
        chk("C_silent", cnt, 0);
        send(1, 7);
        t0 = cyc;
        step();
        chk("C_enable_done", int'(cfg_done), 1);
        for (int k = 2; k <= 15; k++) begin
            step();
            if (k == 7)  chk("C_no_early_tick", int'(tick[1]), 0);
            if (k == 8)  chk("C_first_tick", int'(tick[1]), 1);
            if (k == 15) chk("C_second_tick", int'(tick[1]), 1);
        end

        // run dropped while waiting for ch2's wrap
        for (int g = 0; g < 60 && ((cyc - m_start[2]) % m_div[2]) != 2; g++) step();
        send(2, 9);
        repeat (3) step();
        chk("D_still_waiting", int'(cfg_ready), 0);
        run = 1'b0;
        step();
        chk("D_done", int'(cfg_done), 1);
        chk("D_tick_off", int'(tick), 0);
        repeat (4) step();
        run  = 1'b1;
        base = cyc;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 7) chk("D_ch1_tick", int'(tick[1]), 1);
            if (k == 8) chk("D_ch2_no_tick", int'(tick[2]), 0);
            if (k == 9) chk("D_ch2_first_tick", int'(tick[2]), 1);
        end

        // reset while a request is pending
        send(2, 5);
        step();
        chk("E_pending", int'(cfg_ready), 0);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("E_async_reset", int'({tick, cfg_ready, cfg_done, cfg_err}), 6'b000100);
        repeat (3) step();
        sys_rst_n = 1'b1;
        base = cyc;
        cnt  = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            cnt += int'(cfg_done);
            if (k == 49) chk("E_ch2_default_quiet", int'(tick[2]), 0);
            if (k == 50) chk("E_ch2_default_tick", int'(tick[2]), 1);
        end
        chk("E_no_done", cnt, 0);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            run       = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 3'($urandom_range(0, 4));
            cfg_div   = CW'($urandom_range(0, 8));
            step();
        end
        cfg_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
